// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, funcs, ALU and mux selects.
// No logic; imported by the controller and its ALU-op decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTEXEC,
    RTWB,
    IEXEC,
    IWB,
    BRANCH,
    JUMP,
    JAL,
    JR,
    HALT
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  // Raw (ungated) control word; PCLoad is derived from pcWrite/pcWriteCond.
  typedef struct packed {
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       jalSig1;
    logic       memToReg;
    logic       jalSig2;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOperation;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       pcWriteCond;
  } ctrl_t;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type func -> ALUOperation, combinational; unknown funcs map to add with funcValid=0.
// Zero latency, no backpressure.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] aluOp,
  output logic       funcValid
);

  always_comb begin
    aluOp     = ALU_ADD;
    funcValid = 1'b1;
    case (func)
      FUNC_ADD: aluOp = ALU_ADD;
      FUNC_SUB: aluOp = ALU_SUB;
      FUNC_AND: aluOp = ALU_AND;
      FUNC_OR:  aluOp = ALU_OR;
      FUNC_SLT: aluOp = ALU_SLT;
      default:  funcValid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM; Moore strobes per phase, memory phases stretched by MEM_WAIT cycles.
// No backpressure; CTRL_ILLEGAL_TRAP_EN adds a `halted` port and a halt-on-illegal-opcode state.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       halted
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  state_t     stateNext;
  logic [3:0] waitCnt;
  logic       lastWait;
  logic [2:0] rtAluOp;
  logic       rtFuncValid;
  ctrl_t      ctl;

  alu_op_decoder uAluOpDecoder (
    .func      (func),
    .aluOp     (rtAluOp),
    .funcValid (rtFuncValid)
  );

  assign lastWait = (waitCnt == WAIT_LAST);

  // Counter restarts on every state change, so each memory state begins at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state) begin
        waitCnt <= '0;
      end else if (waitCnt < WAIT_LAST) begin
        waitCnt <= waitCnt + 4'd1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:  if (lastWait) stateNext = DECODE;
      DECODE: begin
        case (opc)
          OPC_LW, OPC_SW:     stateNext = MEMADR;
          OPC_RTYPE:          stateNext = (func == FUNC_JR) ? JR : RTEXEC;
          OPC_BEQ:            stateNext = BRANCH;
          OPC_ADDI, OPC_SLTI: stateNext = IEXEC;
          OPC_J:              stateNext = JUMP;
          OPC_JAL:            stateNext = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:            stateNext = HALT;
`else
          default:            stateNext = FETCH;
`endif
        endcase
      end
      MEMADR: stateNext = (opc == OPC_SW) ? MEMWR : MEMRD;
      MEMRD:  if (lastWait) stateNext = MEMWB;
      MEMWR:  if (lastWait) stateNext = FETCH;
      RTEXEC: stateNext = RTWB;
      IEXEC:  stateNext = IWB;
      MEMWB, RTWB, IWB, BRANCH, JUMP, JAL, JR: stateNext = FETCH;
      HALT:   stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.memRead      = 1'b1;
        ctl.aluSrcB      = SRCB_FOUR;
        ctl.aluOperation = ALU_ADD;
        ctl.pcSrc        = PCSRC_ALU;
        ctl.irWrite      = lastWait;
        ctl.pcWrite      = lastWait;
      end
      DECODE: begin
        ctl.aluSrcB      = SRCB_BRANCH;
        ctl.aluOperation = ALU_ADD;
      end
      MEMADR: begin
        ctl.aluSrcA      = 1'b1;
        ctl.aluSrcB      = SRCB_IMM;
        ctl.aluOperation = ALU_ADD;
      end
      MEMRD: begin
        ctl.iorD    = 1'b1;
        ctl.memRead = 1'b1;
      end
      MEMWB: ctl.regWrite = 1'b1;
      MEMWR: begin
        ctl.iorD     = 1'b1;
        ctl.memWrite = 1'b1;
      end
      RTEXEC: begin
        ctl.aluSrcA      = 1'b1;
        ctl.aluSrcB      = SRCB_REG;
        ctl.aluOperation = rtAluOp;
      end
      // IR is stable here, so the func decode can still veto the write.
      RTWB: begin
        ctl.regDst   = 1'b1;
        ctl.memToReg = 1'b1;
        ctl.regWrite = rtFuncValid;
      end
      IEXEC: begin
        ctl.aluSrcA      = 1'b1;
        ctl.aluSrcB      = SRCB_IMM;
        ctl.aluOperation = (opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
      end
      IWB: begin
        ctl.memToReg = 1'b1;
        ctl.regWrite = 1'b1;
      end
      BRANCH: begin
        ctl.aluSrcA      = 1'b1;
        ctl.aluSrcB      = SRCB_REG;
        ctl.aluOperation = ALU_SUB;
        ctl.pcSrc        = PCSRC_ALUOUT;
        ctl.pcWriteCond  = 1'b1;
      end
      JUMP: begin
        ctl.pcSrc   = PCSRC_JUMP;
        ctl.pcWrite = 1'b1;
      end
      JAL: begin
        ctl.jalSig1  = 1'b1;
        ctl.jalSig2  = 1'b1;
        ctl.regWrite = 1'b1;
        ctl.pcSrc    = PCSRC_JUMP;
        ctl.pcWrite  = 1'b1;
      end
      JR: begin
        ctl.pcSrc   = PCSRC_REGA;
        ctl.pcWrite = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  // Reset gates every strobe immediately, so an aborted access cannot complete.
  assign PCLoad       = rst & (ctl.pcWrite | (ctl.pcWriteCond & zero));
  assign IorD         = rst & ctl.iorD;
  assign MemRead      = rst & ctl.memRead;
  assign MemWrite     = rst & ctl.memWrite;
  assign IRWrite      = rst & ctl.irWrite;
  assign RegDst       = rst & ctl.regDst;
  assign JalSig1      = rst & ctl.jalSig1;
  assign MemToReg     = rst & ctl.memToReg;
  assign JalSig2      = rst & ctl.jalSig2;
  assign RegWrite     = rst & ctl.regWrite;
  assign ALUSrcA      = rst & ctl.aluSrcA;
  assign ALUSrcB      = rst ? ctl.aluSrcB : 2'd0;
  assign ALUOperation = rst ? ctl.aluOperation : 3'd0;
  assign PCSrc        = rst ? ctl.pcSrc : 2'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign halted       = rst & (state == HALT);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: two controllers (MEM_WAIT=0 and 2) run random instruction streams against a per-instruction model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcLoad;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       jalSig1;
    logic       memToReg;
    logic       jalSig2;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       halted;
  } obs_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, JMP = 6'b000010, JALO = 6'b000011;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;
  localparam int FULL = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic [5:0] opc [2];
  logic [5:0] func [2];
  logic       zero [2];
  logic       pcLoad [2], iorD [2], memRead [2], memWrite [2], irWrite [2], regDst [2];
  logic       jalSig1 [2], memToReg [2], jalSig2 [2], regWrite [2], aluSrcA [2];
  logic [1:0] aluSrcB [2];
  logic [2:0] aluOp [2];
  logic [1:0] pcSrc [2];
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       halted [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : gDut
    multicycle_controller #(.MEM_WAIT(2 * g)) dut (
      .clk(clk), .rst(rst[g]), .opc(opc[g]), .func(func[g]), .zero(zero[g]),
      .PCLoad(pcLoad[g]), .IorD(iorD[g]), .MemRead(memRead[g]), .MemWrite(memWrite[g]),
      .IRWrite(irWrite[g]), .RegDst(regDst[g]), .JalSig1(jalSig1[g]), .MemToReg(memToReg[g]),
      .JalSig2(jalSig2[g]), .RegWrite(regWrite[g]), .ALUSrcA(aluSrcA[g]), .ALUSrcB(aluSrcB[g]),
      .ALUOperation(aluOp[g]), .PCSrc(pcSrc[g])
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .halted(halted[g])
`endif
    );
  end

  obs_t  expQ0 [$];
  obs_t  expQ1 [$];
  string nmQ0 [$];
  string nmQ1 [$];
  int    nChecks = 0;
  int    nFails  = 0;

  function automatic obs_t sample(int d);
    obs_t s;
    s.pcLoad = pcLoad[d];   s.iorD = iorD[d];         s.memRead = memRead[d];
    s.memWrite = memWrite[d]; s.irWrite = irWrite[d]; s.regDst = regDst[d];
    s.jalSig1 = jalSig1[d]; s.memToReg = memToReg[d]; s.jalSig2 = jalSig2[d];
    s.regWrite = regWrite[d]; s.aluSrcA = aluSrcA[d]; s.aluSrcB = aluSrcB[d];
    s.aluOp = aluOp[d];     s.pcSrc = pcSrc[d];
`ifdef CTRL_ILLEGAL_TRAP_EN
    s.halted = halted[d];
`else
    s.halted = 1'b0;
`endif
    return s;
  endfunction

  task automatic pushExp(int d, obs_t e, string nm);
    if (d == 0) begin expQ0.push_back(e); nmQ0.push_back(nm); end
    else begin expQ1.push_back(e); nmQ1.push_back(nm); end
  endtask

  task automatic put(int d, obs_t c, string nm, int limit, inout int n);
    if (n < limit) pushExp(d, c, nm);
    n++;
  endtask

  task automatic checkOne(int d);
    obs_t got, exp;
    string nm;
    got = sample(d);
    if (d == 0) begin
      if (expQ0.size() == 0) return;
      exp = expQ0.pop_front(); nm = nmQ0.pop_front();
    end else begin
      if (expQ1.size() == 0) return;
      exp = expQ1.pop_front(); nm = nmQ1.pop_front();
    end
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s dut%0d t=%0t: got %h required %h", nm, d, $time, got, exp);
    end
  endtask

  // Monitor: every falling edge, compare each DUT against its next expected cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) checkOne(d);
    end
  end

  function automatic bit isLegal(logic [5:0] o);
    return o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == SLTI || o == JMP || o == JALO;
  endfunction

  // Reference model: the per-cycle control words one instruction should produce.
  task automatic expectInstr(int d, logic [5:0] o, logic [5:0] f, logic z, int limit, inout int n);
    obs_t c;
    int   w;
    w = 2 * d;
    for (int i = 0; i <= w; i++) begin
      c = '0; c.memRead = 1'b1; c.aluSrcB = 2'd1; c.aluOp = A_ADD;
      if (i == w) begin c.irWrite = 1'b1; c.pcLoad = 1'b1; end
      put(d, c, "fetch", limit, n);
    end
    c = '0; c.aluSrcB = 2'd3; c.aluOp = A_ADD;
    put(d, c, "decode", limit, n);
    if (o == LW || o == SW) begin
      c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = A_ADD;
      put(d, c, "memadr", limit, n);
      for (int i = 0; i <= w; i++) begin
        c = '0; c.iorD = 1'b1;
        if (o == LW) c.memRead = 1'b1; else c.memWrite = 1'b1;
        put(d, c, (o == LW) ? "memrd" : "memwr", limit, n);
      end
      if (o == LW) begin
        c = '0; c.regWrite = 1'b1;
        put(d, c, "memwb", limit, n);
      end
    end else if (o == RT && f == 6'b001000) begin
      c = '0; c.pcSrc = 2'd3; c.pcLoad = 1'b1;
      put(d, c, "jr", limit, n);
    end else if (o == RT) begin
      c = '0; c.aluSrcA = 1'b1;
      case (f)
        6'b100000: c.aluOp = A_ADD;
        6'b100010: c.aluOp = A_SUB;
        6'b100100: c.aluOp = A_AND;
        6'b100101: c.aluOp = A_OR;
        6'b101010: c.aluOp = A_SLT;
        default:   c.aluOp = A_ADD;
      endcase
      put(d, c, "rtexec", limit, n);
      c = '0; c.regDst = 1'b1; c.memToReg = 1'b1;
      c.regWrite = (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010);
      put(d, c, "rtwb", limit, n);
    end else if (o == BEQ) begin
      c = '0; c.aluSrcA = 1'b1; c.aluOp = A_SUB; c.pcSrc = 2'd2; c.pcLoad = z;
      put(d, c, "branch", limit, n);
    end else if (o == ADDI || o == SLTI) begin
      c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = (o == SLTI) ? A_SLT : A_ADD;
      put(d, c, "iexec", limit, n);
      c = '0; c.memToReg = 1'b1; c.regWrite = 1'b1;
      put(d, c, "iwb", limit, n);
    end else if (o == JMP) begin
      c = '0; c.pcSrc = 2'd1; c.pcLoad = 1'b1;
      put(d, c, "jump", limit, n);
    end else if (o == JALO) begin
      c = '0; c.jalSig1 = 1'b1; c.jalSig2 = 1'b1; c.regWrite = 1'b1; c.pcSrc = 2'd1; c.pcLoad = 1'b1;
      put(d, c, "jal", limit, n);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runInstr(int d, logic [5:0] o, logic [5:0] f, logic z, int limit);
    int n;
    n = 0;
    opc[d] = o; func[d] = f; zero[d] = z;
    expectInstr(d, o, f, z, limit, n);
    cyc((n < limit) ? n : limit);
  endtask

  task automatic doReset(int d, int cycles);
    rst[d] = 1'b0;
    for (int i = 0; i < cycles; i++) pushExp(d, obs_t'(0), "reset");
    cyc(cycles);
    rst[d] = 1'b1;
  endtask

  task automatic runDut(int d);
    logic [5:0] o, f;
    logic       z;
    int         kind;
    doReset(d, 3);
    runInstr(d, LW, 6'h00, 1'b0, FULL);
    runInstr(d, RT, 6'b101010, 1'b0, FULL);
    runInstr(d, BEQ, 6'h00, 1'b1, FULL);
    runInstr(d, BEQ, 6'h00, 1'b0, FULL);
    runInstr(d, JALO, 6'h00, 1'b0, FULL);
    runInstr(d, RT, 6'b001000, 1'b0, FULL);
    runInstr(d, SW, 6'h00, 1'b0, FULL);
    runInstr(d, SLTI, 6'h00, 1'b0, FULL);
    runInstr(d, RT, 6'b111111, 1'b1, FULL);
    // Abort a store inside its write phase.
    runInstr(d, SW, 6'h00, 1'b0, 2 * d + 3 + ((d > 0) ? 1 : 0));
    doReset(d, 2);
    for (int k = 0; k < 70; k++) begin
      kind = $urandom_range(0, 9);
      f = 6'($urandom);
      z = 1'($urandom);
      case (kind)
        0: o = LW;
        1: o = SW;
        2: begin
          o = RT;
          case ($urandom_range(0, 5))
            0: f = 6'b100000;
            1: f = 6'b100010;
            2: f = 6'b100100;
            3: f = 6'b100101;
            4: f = 6'b101010;
            default: ;
          endcase
        end
        3: begin o = RT; f = 6'b001000; end
        4: o = BEQ;
        5: o = ADDI;
        6: o = SLTI;
        7: o = JMP;
        8: o = JALO;
        default: o = 6'($urandom);
      endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (!isLegal(o)) o = JMP;
`endif
      runInstr(d, o, f, z, FULL);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    runInstr(d, 6'b111111, 6'h00, 1'b0, FULL);
    for (int i = 0; i < 6; i++) pushExp(d, obs_t'(1), "halt");
    cyc(6);
    doReset(d, 2);
    runInstr(d, LW, 6'h00, 1'b0, FULL);
`else
    if (isLegal(6'b111111)) $display("note: opcode 111111 unexpectedly legal in model");
    runInstr(d, 6'b111111, 6'h00, 1'b0, FULL);
    runInstr(d, ADDI, 6'h00, 1'b0, FULL);
`endif
  endtask

  task automatic summary;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; opc[d] = '0; func[d] = '0; zero[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    fork
      runDut(0);
      runDut(1);
    join
    nChecks++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      nFails++;
      $display("FAIL drain: got %0d/%0d pending required 0/0", expQ0.size(), expQ1.size());
    end
    summary();
    $finish;
  end

  initial begin
    #500000;
    nFails++;
    $display("FAIL watchdog: got timeout required completion");
    summary();
    $finish;
  end

endmodule
